// File: rtl/id_ex_if.sv
// ID/EX stage bundle: decoded control and operand fields entering EX,
// their registered copies, hazard feedback and the bubble/flush counters.
interface id_ex_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  // pipeline control from the hazard / branch logic
  logic                  stall_ctrl;
  logic                  flush;

  // decode-side fields
  logic                  id_reg_dst;
  logic                  id_alu_src;
  logic                  id_mem_to_reg;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic                  id_branch;
  logic                  id_jump;
  logic [2:0]            id_alu_op;
  logic [DATA_WIDTH-1:0] id_pc_plus4;
  logic [DATA_WIDTH-1:0] id_read_data1;
  logic [DATA_WIDTH-1:0] id_read_data2;
  logic [DATA_WIDTH-1:0] id_sign_imm;
  logic [4:0]            id_rs;
  logic [4:0]            id_rt;
  logic [4:0]            id_rd;
  logic [4:0]            id_shamt;

  // execute-side registered fields
  logic                  ex_reg_dst;
  logic                  ex_alu_src;
  logic                  ex_mem_to_reg;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_branch;
  logic                  ex_jump;
  logic [2:0]            ex_alu_op;
  logic [DATA_WIDTH-1:0] ex_pc_plus4;
  logic [DATA_WIDTH-1:0] ex_read_data1;
  logic [DATA_WIDTH-1:0] ex_read_data2;
  logic [DATA_WIDTH-1:0] ex_sign_imm;
  logic [4:0]            ex_rs;
  logic [4:0]            ex_rt;
  logic [4:0]            ex_rd;
  logic [4:0]            ex_shamt;
  logic                  ex_valid;

  // hazard feedback and debug counters
  logic                  lw_detected;
  logic [4:0]            ID_EX_rt;
  logic [CNT_WIDTH-1:0]  bubble_cnt;
  logic [CNT_WIDTH-1:0]  flush_cnt;

  // decode / hazard side
  modport master (
    output stall_ctrl, flush,
    output id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write,
    output id_mem_read, id_mem_write, id_branch, id_jump, id_alu_op,
    output id_pc_plus4, id_read_data1, id_read_data2, id_sign_imm,
    output id_rs, id_rt, id_rd, id_shamt,
    input  ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
    input  ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_op,
    input  ex_pc_plus4, ex_read_data1, ex_read_data2, ex_sign_imm,
    input  ex_rs, ex_rt, ex_rd, ex_shamt, ex_valid,
    input  lw_detected, ID_EX_rt, bubble_cnt, flush_cnt
  );

  // the pipeline register itself
  modport slave (
    input  stall_ctrl, flush,
    input  id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write,
    input  id_mem_read, id_mem_write, id_branch, id_jump, id_alu_op,
    input  id_pc_plus4, id_read_data1, id_read_data2, id_sign_imm,
    input  id_rs, id_rt, id_rd, id_shamt,
    output ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
    output ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_op,
    output ex_pc_plus4, ex_read_data1, ex_read_data2, ex_sign_imm,
    output ex_rs, ex_rt, ex_rd, ex_shamt, ex_valid,
    output lw_detected, ID_EX_rt, bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register. Loads decode fields every edge; a flush or a
// stall request turns the slot into a bubble by clearing all control bits
// while datapath and register indices still follow decode. Keeps
// saturating bubble/flush counters for performance debug.
module id_ex_stage_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic   clk,
  input  logic   reset,      // asynchronous, active low
  id_ex_if.slave bus
);

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_BUBBLE,
    ACT_FLUSH
  } act_e;

  localparam int CTRL_W = 11;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  act_e                  act;
  logic [CTRL_W-1:0]     id_ctrl;
  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic [DATA_WIDTH-1:0] read_data1_q, read_data1_d;
  logic [DATA_WIDTH-1:0] read_data2_q, read_data2_d;
  logic [DATA_WIDTH-1:0] sign_imm_q, sign_imm_d;
  logic [4:0]            rs_q, rs_d;
  logic [4:0]            rt_q, rt_d;
  logic [4:0]            rd_q, rd_d;
  logic [4:0]            shamt_q, shamt_d;
  logic [CNT_WIDTH-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

  // Control bits bundled so a bubble can clear them in one place.
  assign id_ctrl = {bus.id_reg_dst, bus.id_alu_src, bus.id_mem_to_reg,
                    bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
                    bus.id_branch, bus.id_jump, bus.id_alu_op};

  // Per-cycle action: flush outranks the stall request.
  always_comb begin
    act = ACT_LOAD;
    if (bus.flush)            act = ACT_FLUSH;
    else if (!bus.stall_ctrl) act = ACT_BUBBLE;
  end

  // Next-state: datapath always follows decode, control only on LOAD.
  always_comb begin
    ctrl_d       = '0;
    valid_d      = 1'b0;
    pc_plus4_d   = bus.id_pc_plus4;
    read_data1_d = bus.id_read_data1;
    read_data2_d = bus.id_read_data2;
    sign_imm_d   = bus.id_sign_imm;
    rs_d         = bus.id_rs;
    rt_d         = bus.id_rt;
    rd_d         = bus.id_rd;
    shamt_d      = bus.id_shamt;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    case (act)
      ACT_LOAD: begin
        ctrl_d  = id_ctrl;
        valid_d = 1'b1;
      end
      ACT_BUBBLE: begin
        if (bubble_cnt_q != CNT_MAX) bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
      ACT_FLUSH: begin
        if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
      end
      default: begin
        ctrl_d  = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Stage register with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q       <= '0;
      valid_q      <= 1'b0;
      pc_plus4_q   <= '0;
      read_data1_q <= '0;
      read_data2_q <= '0;
      sign_imm_q   <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      shamt_q      <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      valid_q      <= valid_d;
      pc_plus4_q   <= pc_plus4_d;
      read_data1_q <= read_data1_d;
      read_data2_q <= read_data2_d;
      sign_imm_q   <= sign_imm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      shamt_q      <= shamt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign {bus.ex_reg_dst, bus.ex_alu_src, bus.ex_mem_to_reg,
          bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
          bus.ex_branch, bus.ex_jump, bus.ex_alu_op} = ctrl_q;

  assign bus.ex_valid      = valid_q;
  assign bus.ex_pc_plus4   = pc_plus4_q;
  assign bus.ex_read_data1 = read_data1_q;
  assign bus.ex_read_data2 = read_data2_q;
  assign bus.ex_sign_imm   = sign_imm_q;
  assign bus.ex_rs         = rs_q;
  assign bus.ex_rt         = rt_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_shamt      = shamt_q;
  assign bus.bubble_cnt    = bubble_cnt_q;
  assign bus.flush_cnt     = flush_cnt_q;

  // Hazard feedback comes only from registered state, keeping the
  // hazard unit free of a combinational loop through this stage.
  assign bus.lw_detected   = valid_q & ctrl_q[6];
  assign bus.ID_EX_rt      = rt_q;

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register of the 5-stage MIPS core, sitting between decode and execute. Captures decoded control and operand fields on every clock edge. When the hazard detection unit requests a stall or branch/jump resolution requests a flush, it inserts a bubble by zeroing all control fields. It feeds the load-use indicators (`lw_detected`, `ID_EX_rt`) back to the hazard detection unit, and keeps saturating bubble/flush counters for performance debug.

## Interface
- `DATA_WIDTH`, 32: width of PC and operand datapath fields
- `CNT_WIDTH`, 16: width of each saturating event counter
- `clk` in 1: pipeline clock, all state updates on rising edge
- `reset` in 1: asynchronous, active-low reset
- `stall_ctrl` in 1: from hazard detection unit; 0 = insert bubble this cycle, 1 = normal load
- `flush` in 1: active-high; branch taken / jump resolved; kill the instruction entering EX
- `id_reg_dst`, `id_alu_src`, `id_mem_to_reg`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_branch`, `id_jump` in 1 each: decoded control
- `id_alu_op` in 3: ALU operation class
- `id_pc_plus4`, `id_read_data1`, `id_read_data2`, `id_sign_imm` in DATA_WIDTH: decode datapath
- `id_rs`, `id_rt`, `id_rd`, `id_shamt` in 5 each: instruction fields
- `ex_*` out (same widths): registered copies of every `id_*` input
- `ex_valid` out 1: EX-stage slot holds a real instruction
- `lw_detected` out 1: `ex_valid & ex_mem_read`
- `ID_EX_rt` out 5: equals `ex_rt`; destination of a load in EX
- `bubble_cnt`, `flush_cnt` out CNT_WIDTH: saturating event counters

## Operation
- Per-cycle action, in priority order:
  - reset low
  - else `flush`=1 → FLUSH
  - else `stall_ctrl`=0 → BUBBLE
  - else LOAD
- LOAD: all `ex_*` fields take their `id_*` values; `ex_valid` <= 1.
- BUBBLE and FLUSH:
  - Control outputs clear to 0: `ex_reg_dst`, `ex_alu_src`, `ex_mem_to_reg`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch`, `ex_jump`, `ex_alu_op`.
  - `ex_valid` <= 0.
  - Datapath and register-index fields (`pc_plus4`, `read_data1/2`, `sign_imm`, `rs`, `rt`, `rd`, `shamt`) still load from `id_*`. The forwarding unit sees current indices; a bubble can never write the register file or memory.
- Counters:
  - `bubble_cnt` +1 on each BUBBLE cycle.
  - `flush_cnt` +1 on each FLUSH cycle.
  - Both saturate at 2^CNT_WIDTH-1 and never wrap.
- Simultaneous `flush`=1 and `stall_ctrl`=0: FLUSH only. `flush_cnt` increments, `bubble_cnt` unchanged.
- `lw_detected` and `ID_EX_rt` are combinational from registered state only; no path from any `id_*` input or `stall_ctrl`. This breaks the hazard-unit loop.
- Reset asserted mid-operation: all state clears immediately (asynchronous), regardless of the clock. The first LOAD happens on the first rising edge after `reset` returns high with `stall_ctrl`=1 and `flush`=0.

## Timing
- Reset values: every `ex_*` output = 0, `ex_valid` = 0, `lw_detected` = 0, `ID_EX_rt` = 0, both counters = 0.
- Latency: 1 cycle from `id_*` to `ex_*`.
- Bubble inserted at edge N appears on the `ex_*` outputs during cycle N+1.
- Hazard unit contract: it holds PC and IF/ID in the same cycle `stall_ctrl`=0. The stalled instruction is re-presented on `id_*` at edge N+1 and loads then.
- `lw_detected` drops in the cycle after a bubble is inserted (`ex_valid`=0). A single load-use produces exactly one bubble.
- Counter update visible 1 cycle after the qualifying edge.

## Test plan
- Reset → all outputs 0; release reset, `stall_ctrl`=1, drive `id_rt`=5, `id_mem_read`=1, `id_reg_write`=1 → next cycle `ex_valid`=1, `lw_detected`=1, `ID_EX_rt`=5.
- Load-use: cycle 0 `stall_ctrl`=0 with `id_rt`=5, `id_reg_write`=1, `id_alu_op`=3'b010 → cycle 1 all control 0, `ex_valid`=0, `ex_rt`=5, `lw_detected`=0, `bubble_cnt`=1.
- Flush: `flush`=1 with `id_branch`=1, `id_mem_write`=1 → next cycle `ex_branch`=0, `ex_mem_write`=0, `flush_cnt`=1, `bubble_cnt` unchanged.
- Simultaneous `flush`=1 and `stall_ctrl`=0 for 3 cycles → `flush_cnt`=3, `bubble_cnt`=0, `ex_valid`=0 throughout.
- Saturation: CNT_WIDTH=4, 20 consecutive bubbles → `bubble_cnt`=15 and stays 15.
- Async reset pulse between edges while `ex_valid`=1 and counters nonzero → all outputs 0 before the next rising edge; no update at the edge while `reset`=0.
